apb_regfile_port: RTL
=====================

Name: apb_regfile_port

Overview:
APB responder that gives an external bus master read and write access to the 16 x 16-bit core register file. It turns APB setup/access transactions into register-file reads and single-cycle writes. The core keeps priority on the shared write port; the block holds off its own writes, stretching the APB access with PREADY low, while the core is writing. It sits between the SoC APB interconnect and the register file's spare read port and external write mux.

Parameters:
WAIT_STATES, 1, extra access-phase cycles inserted before commit (legal 0..15, 4-bit counter)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  8  byte address; register index = paddr[5:2]
pwdata  input  16  APB write data
prdata  output  16  APB read data, valid only while pready=1
pready  output  1  transfer complete, one-cycle pulse
pslverr  output  1  transfer error, valid only while pready=1
core_w_en  input  1  core is using the register-file write port this cycle
rf_addr_read  output  4  register-file read address
rf_read_data  input  16  asynchronous read data from register file
rf_w_en  output  1  write strobe to register-file write mux
rf_addr_write  output  4  register-file write address
rf_data_write  output  16  register-file write data

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cnt=0, latched address/data/write/error=0. prdata=0, pready=0, pslverr=0. rf_w_en=0. Reset overrides everything in the same cycle, and no write is issued during a reset cycle.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Setup phase is psel=1 and penable=0.
  - On setup: latch idx=paddr[5:2], wdata=pwdata, wr=pwrite.
  - Latch err=1 if paddr[1:0]!=0 or paddr[7:6]!=0.
  - Load cnt=WAIT_STATES and go to WAIT.
  - psel=1 with penable=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - If psel=0 (master abort): go to IDLE with no write and no response.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else if wr=1, err=0 and core_w_en=1: stay in WAIT (retry next cycle, cnt stays 0).
  - Else commit and go to RESP.
- Commit cycle:
  - rf_w_en is combinational: rf_w_en = (state==WAIT) and cnt==0 and psel and wr and !err and !core_w_en and !reset. The register file captures the write on the edge ending this cycle.
  - Registered on the same edge: pready<=1, pslverr<=err.
  - Registered on the same edge: prdata<=rf_read_data if (!wr and !err), otherwise 0.
- RESP: pready=1 for exactly one cycle, then IDLE with pready=0, pslverr=0, prdata=0. A new setup phase may arrive in the cycle after RESP (back-to-back transfers). No setup is accepted during RESP.
- rf_addr_read = rf_addr_write = latched idx; rf_data_write = latched wdata. Both are stable from WAIT entry until the return to IDLE.
- Latency with no core conflict: PREADY rises WAIT_STATES+2 cycles after the setup cycle. For WAIT_STATES=0, that is setup at T0, commit at T1, PREADY at T2.
- Errored writes never assert rf_w_en. Errored reads return prdata=0 with pslverr=1.
- A read issued in the same commit cycle as a core write to the same index returns the old value (asynchronous read before the write edge).
- Each core_w_en cycle at commit adds exactly one cycle of latency. There is no starvation limit; the core has absolute priority.

Test Plan:
- Reset then idle, WAIT_STATES=1 -> prdata=0, pready=0, pslverr=0, rf_w_en=0 for 10 cycles.
- APB write paddr=0x14, pwdata=0xBEEF -> rf_w_en high exactly 1 cycle with rf_addr_write=5, rf_data_write=0xBEEF. pready high 3 cycles after setup, pslverr=0.
- APB read paddr=0x14 after that write -> prdata=0xBEEF with pready=1 and pslverr=0. prdata=0 in the following cycle.
- Write paddr=0x15 (misaligned) and read paddr=0x40 (out of range) -> pslverr=1 with pready, rf_w_en never asserted, prdata=0.
- Write paddr=0x08 with core_w_en held high for 3 cycles around commit -> rf_w_en only after core_w_en falls, pready delayed by exactly 3 cycles, register 2 receives the APB data.
- Reset pulsed in WAIT during a write, and a separate write with psel dropped in WAIT -> no rf_w_en, no pready, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_regfile_port_if.sv
// APB bus bundle between the SoC interconnect and the register-file port.
// Latency: none (wires only).
// Backpressure: the slave stretches the access phase by holding pready low.
interface apb_regfile_port_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_port.sv
// APB responder giving a bus master access to the 16 x 16-bit register file.
// Latency: pready rises WAIT_STATES+2 cycles after setup, +1 per cycle the core holds the write port.
// Backpressure: core writes have absolute priority; the access phase stretches with pready low.
module apb_regfile_port #(
  parameter int WAIT_STATES = 1
) (
  input  logic                clock,
  input  logic                reset,
  apb_regfile_port_if.slave   apb,
  input  logic                core_w_en,
  output logic [3:0]          rf_addr_read,
  input  logic [15:0]         rf_read_data,
  output logic                rf_w_en,
  output logic [3:0]          rf_addr_write,
  output logic [15:0]         rf_data_write
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [3:0]  idx;
  logic [15:0] wdata;
  logic        wr;
  logic        err;
  logic [15:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;

  logic wait_done;
  logic core_block;
  logic commit;

  // Wait states exhausted and the master is still holding the transfer.
  assign wait_done  = (state == ST_WAIT) && apb.psel && (cnt == 4'd0);
  // Only a legal write contends with the core; reads and errored writes go through.
  assign core_block = wr && !err && core_w_en;
  assign commit     = wait_done && !core_block;

  // The register file samples this strobe on the edge that ends the commit cycle.
  assign rf_w_en       = commit && wr && !err && !reset;
  assign rf_addr_read  = idx;
  assign rf_addr_write = idx;
  assign rf_data_write = wdata;

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

  // Transfer sequencing: latch on setup, count wait states, commit, one-cycle response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      idx       <= 4'd0;
      wdata     <= 16'd0;
      wr        <= 1'b0;
      err       <= 1'b0;
      prdata_q  <= 16'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // psel with penable already high is a protocol violation and is ignored.
          if (apb.psel && !apb.penable) begin
            idx   <= apb.paddr[5:2];
            wdata <= apb.pwdata;
            wr    <= apb.pwrite;
            err   <= (apb.paddr[1:0] != 2'd0) || (apb.paddr[7:6] != 2'd0);
            cnt   <= 4'(WAIT_STATES);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!apb.psel) begin
            state <= ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!core_block) begin
            // Read data is taken before the write edge, so a colliding core write is not seen.
            state     <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err;
            prdata_q  <= (!wr && !err) ? rf_read_data : 16'd0;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= 16'd0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
